// File: rtl/matrix_scan_ctrl.sv
// Row-slot scan controller for the 8x8 red/green LED matrix and 6-digit 7-segment display.
// Fetches one row per slot from the game or banner source, blanks for anti-ghosting, then drives it.
module matrix_scan_ctrl #(
  parameter int unsigned SLOT_CYC  = 8192,
  parameter int unsigned BLANK_CYC = 64,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src_sel,
  input  logic        lz_en,
  input  logic [23:0] bcd_in,
  input  logic        rd_valid,
  input  logic [7:0]  rd_r,
  input  logic [7:0]  rd_g,
  output logic        rd_req,
  output logic [2:0]  rd_row,
  output logic        rd_src,
  output logic        active_src,
  output logic        frame_start,
  output logic        fetch_err,
  output logic [7:0]  matrix_scanout,
  output logic [7:0]  matrix_segout_r,
  output logic [7:0]  matrix_segout_g,
  output logic [2:0]  led_scanout,
  output logic [7:0]  led_segout
);

  localparam int unsigned CW = $clog2(SLOT_CYC);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] c;
  logic [2:0]    row;
  logic [TW-1:0] tcnt;
  logic [7:0]    lat_r, lat_g;
  logic          slot_start, slot_last, disp_load;
  logic          fetch_ok, fetch_to;
  logic [7:0]    disp_r, disp_g;
  logic [3:0]    dig, dig_first;
  logic [1:0]    pos;
  logic          blank;
  logic [2:0]    led_scan_nxt;
  logic [7:0]    led_seg_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b1111_1100;
      4'd1:    s = 8'b0110_0000;
      4'd2:    s = 8'b1101_1010;
      4'd3:    s = 8'b1111_0010;
      4'd4:    s = 8'b0110_0110;
      4'd5:    s = 8'b1011_0110;
      4'd6:    s = 8'b1011_1110;
      4'd7:    s = 8'b1110_0000;
      4'd8:    s = 8'b1111_1110;
      4'd9:    s = 8'b1111_0110;
      default: s = 8'b0000_0000;
    endcase
    return s;
  endfunction

  assign slot_start = (c == '0);
  assign slot_last  = (c == C_LAST);
  assign disp_load  = (c == C_LOAD);
  assign rd_src     = active_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_ok  = 1'b0;
    fetch_to  = 1'b0;
    case (state)
      IDLE:  if (slot_start) state_nxt = FETCH;
      FETCH: begin
        if (rd_valid) begin
          fetch_ok  = 1'b1;
          state_nxt = HOLD;
        end else if (tcnt == T_LAST) begin
          fetch_to  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD:  if (slot_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c           <= '0;
      row         <= 3'd7;
      active_src  <= 1'b0;
      frame_start <= 1'b0;
      fetch_err   <= 1'b0;
      rd_req      <= 1'b0;
      rd_row      <= '0;
      tcnt        <= '0;
      lat_r       <= '0;
      lat_g       <= '0;
    end else begin
      c           <= slot_last ? '0 : c + CW'(1);
      frame_start <= 1'b0;
      fetch_err   <= fetch_to;
      if (slot_start) begin
        row <= row + 3'd1;
        if (row == 3'd7) begin
          active_src  <= src_sel;
          frame_start <= 1'b1;
        end
      end
      if (state == IDLE && state_nxt == FETCH) begin
        rd_req <= 1'b1;
        rd_row <= row + 3'd1;
        tcnt   <= '0;
      end else if (fetch_ok || fetch_to) begin
        rd_req <= 1'b0;
      end
      if (state == FETCH && !fetch_ok && !fetch_to) tcnt <= tcnt + TW'(1);
      if (fetch_ok) begin
        lat_r <= rd_r;
        lat_g <= rd_g;
      end else if (fetch_to) begin
        lat_r <= '0;
        lat_g <= '0;
      end
    end
  end

  // Bypass covers a fetch that resolves on the same edge the display loads.
  always_comb begin
    disp_r = lat_r;
    disp_g = lat_g;
    if (fetch_ok) begin
      disp_r = rd_r;
      disp_g = rd_g;
    end else if (fetch_to) begin
      disp_r = '0;
      disp_g = '0;
    end
  end

  always_comb begin
    dig       = 4'd0;
    dig_first = 4'd0;
    pos       = 2'd0;
    case (row)
      3'd0: dig = bcd_in[23:20];
      3'd1: dig = bcd_in[19:16];
      3'd2: dig = bcd_in[15:12];
      3'd3: dig = bcd_in[11:8];
      3'd4: dig = bcd_in[7:4];
      3'd5: dig = bcd_in[3:0];
      default: dig = 4'd0;
    endcase
    if (row < 3'd3) begin
      dig_first = bcd_in[23:20];
      pos       = row[1:0];
    end else begin
      dig_first = bcd_in[11:8];
      pos       = 2'(row - 3'd3);
    end
    // Each 3-digit group suppresses its own leading zeros; the last digit always shows.
    blank = lz_en && (dig == 4'd0) &&
            ((pos == 2'd0) || ((pos == 2'd1) && (dig_first == 4'd0)));
    led_scan_nxt = '0;
    led_seg_nxt  = '0;
    if (row < 3'd6) begin
      led_scan_nxt = row;
      led_seg_nxt  = blank ? '0 : seg7(dig);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix_scanout  <= '0;
      matrix_segout_r <= '0;
      matrix_segout_g <= '0;
      led_scanout     <= '0;
      led_segout      <= '0;
    end else if (slot_last) begin
      matrix_scanout  <= '0;
      matrix_segout_r <= '0;
      matrix_segout_g <= '0;
      led_scanout     <= '0;
      led_segout      <= '0;
    end else if (disp_load) begin
      matrix_scanout  <= 8'(1) << row;
      matrix_segout_r <= disp_r;
      matrix_segout_g <= disp_g;
      led_scanout     <= led_scan_nxt;
      led_segout      <= led_seg_nxt;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: a table of per-slot vectors plus hand-written reset sequences.
module tb_matrix_scan_ctrl;

  localparam int SLOT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        src_sel = 1'b0;
  logic        lz_en = 1'b0;
  logic [23:0] bcd_in = '0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_r = '0;
  logic [7:0]  rd_g = '0;
  logic        rd_req, rd_src, active_src, frame_start, fetch_err;
  logic [2:0]  rd_row, led_scanout;
  logic [7:0]  matrix_scanout, matrix_segout_r, matrix_segout_g, led_segout;

  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  logic resp_en = 1'b1;

  matrix_scan_ctrl #(.SLOT_CYC(32), .BLANK_CYC(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .src_sel(src_sel), .lz_en(lz_en), .bcd_in(bcd_in),
    .rd_valid(rd_valid), .rd_r(rd_r), .rd_g(rd_g), .rd_req(rd_req), .rd_row(rd_row),
    .rd_src(rd_src), .active_src(active_src), .frame_start(frame_start),
    .fetch_err(fetch_err), .matrix_scanout(matrix_scanout),
    .matrix_segout_r(matrix_segout_r), .matrix_segout_g(matrix_segout_g),
    .led_scanout(led_scanout), .led_segout(led_segout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  row;
    logic [23:0] bcd;
    logic        lz;
    logic        sel;    // src_sel value driven mid-slot
    logic        tmo;    // upstream stays silent this slot
    logic        src;
    logic        frm;
    logic [2:0]  lscan;
    logic [7:0]  lseg;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic [2:0] row, input logic [23:0] bcd, input logic lz,
                              input logic sel, input logic tmo, input logic src, input logic frm,
                              input logic [2:0] lscan, input logic [7:0] lseg);
    vec_t v;
    v.row = row; v.bcd = bcd; v.lz = lz; v.sel = sel; v.tmo = tmo;
    v.src = src; v.frm = frm; v.lscan = lscan; v.lseg = lseg;
    return v;
  endfunction

  function automatic logic [7:0] model_r(input logic [2:0] row, input logic src);
    return 8'hA5 ^ {src, 4'b0000, row};
  endfunction

  function automatic logic [7:0] model_g(input logic [2:0] row);
    return 8'h0F ^ {row, 5'b00000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the upstream model answers the third cycle rd_req is seen high.
  task automatic step();
    @(posedge clk);
    #1;
    if (rd_req) req_cnt++;
    else        req_cnt = 0;
    if (resp_en && rd_req && req_cnt == 3) begin
      rd_valid = 1'b1;
      rd_r     = model_r(rd_row, rd_src);
      rd_g     = model_g(rd_row);
    end else begin
      rd_valid = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_req"}, 32'(rd_req), 0);
    chk({tag, "_rd_row"}, 32'(rd_row), 0);
    chk({tag, "_active_src"}, 32'(active_src), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 0);
    chk({tag, "_mscan"}, 32'(matrix_scanout), 0);
    chk({tag, "_seg_rg"}, {16'd0, matrix_segout_r, matrix_segout_g}, 0);
    chk({tag, "_led"}, {21'd0, led_scanout, led_segout}, 0);
  endtask

  // Runs one full slot starting with the counter at 0 (before the slot's first edge).
  task automatic check_slot(input vec_t v, input int idx);
    string p;
    int    rq;
    int    err_at;
    int    cc;
    logic [7:0] er, eg;
    p      = $sformatf("s%0d", idx);
    rq     = 0;
    err_at = -1;
    er     = v.tmo ? 8'h00 : model_r(v.row, v.src);
    eg     = v.tmo ? 8'h00 : model_g(v.row);
    bcd_in  = v.bcd;
    lz_en   = v.lz;
    resp_en = !v.tmo;
    for (int c = 1; c <= SLOT; c++) begin
      step();
      cc = c % SLOT;
      if (rd_req) rq++;
      if (fetch_err) err_at = (err_at < 0) ? cc : 100;
      if (cc == 1) begin
        chk({p, "_frame_start"}, 32'(frame_start), 32'(v.frm));
        chk({p, "_rd_req"}, 32'(rd_req), 1);
        chk({p, "_rd_row"}, 32'(rd_row), 32'(v.row));
        chk({p, "_rd_src"}, 32'(rd_src), 32'(v.src));
        chk({p, "_active_src"}, 32'(active_src), 32'(v.src));
        chk({p, "_dark_c1"}, 32'(matrix_scanout), 0);
      end
      if (cc == 2) chk({p, "_frame_pulse"}, 32'(frame_start), 0);
      if (cc == 7) chk({p, "_dark_c7"}, {matrix_scanout, matrix_segout_r, led_segout}, 0);
      if (cc == 8) begin
        chk({p, "_mscan"}, 32'(matrix_scanout), 32'(8'(1) << v.row));
        chk({p, "_seg_r"}, 32'(matrix_segout_r), 32'(er));
        chk({p, "_seg_g"}, 32'(matrix_segout_g), 32'(eg));
        chk({p, "_led_scan"}, 32'(led_scanout), 32'(v.lscan));
        chk({p, "_led_seg"}, 32'(led_segout), 32'(v.lseg));
      end
      if (cc == 9) bcd_in = 24'h999999;
      if (cc == 10) src_sel = v.sel;
      if (cc == 31) begin
        chk({p, "_led_seg_hold"}, 32'(led_segout), 32'(v.lseg));
        chk({p, "_mscan_hold"}, 32'(matrix_scanout), 32'(8'(1) << v.row));
        chk({p, "_src_hold"}, 32'(active_src), 32'(v.src));
      end
      if (cc == 0) chk({p, "_dark_c0"}, {matrix_scanout, matrix_segout_g, led_segout}, 0);
    end
    chk({p, "_req_cycles"}, 32'(rq), v.tmo ? 32'd4 : 32'd3);
    chk({p, "_fetch_err_at"}, 32'(err_at), v.tmo ? 32'd5 : 32'hFFFF_FFFF);
  endtask

  initial begin
    //              row  bcd       lz    sel   tmo   src   frm   lscan lseg
    vecs[0]  = mk(3'd0, 24'h000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    vecs[1]  = mk(3'd1, 24'h000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00);
    vecs[2]  = mk(3'd2, 24'h000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'hFC);
    vecs[3]  = mk(3'd3, 24'h000007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
    vecs[4]  = mk(3'd4, 24'h000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00);
    vecs[5]  = mk(3'd5, 24'h000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'hE0);
    vecs[6]  = mk(3'd6, 24'h000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    vecs[7]  = mk(3'd7, 24'h000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    vecs[8]  = mk(3'd0, 24'h000007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFC);
    vecs[9]  = mk(3'd1, 24'h000007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'hFC);
    vecs[10] = mk(3'd2, 24'h123486, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'hF2);
    vecs[11] = mk(3'd3, 24'h123486, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h66);
    vecs[12] = mk(3'd4, 24'h123486, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'hFE);
    vecs[13] = mk(3'd5, 24'h000089, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 8'hF6);
    vecs[14] = mk(3'd6, 24'h888888, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    vecs[15] = mk(3'd7, 24'h888888, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    vecs[16] = mk(3'd0, 24'hA00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    vecs[17] = mk(3'd1, 24'h012000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h60);
    vecs[18] = mk(3'd2, 24'h006000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'hBE);
    vecs[19] = mk(3'd3, 24'h006000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00);
    vecs[20] = mk(3'd4, 24'h000300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 8'hFC);
    vecs[21] = mk(3'd5, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'hDA);
    vecs[22] = mk(3'd6, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    vecs[23] = mk(3'd7, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    vecs[24] = mk(3'd0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
    vecs[25] = mk(3'd1, 24'h100000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'hFC);

    #23;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) check_slot(vecs[i], i);

    // Reset asserted at c=1 of the row-2 slot, mid-fetch.
    step();
    chk("pre_reset_rd_req", 32'(rd_req), 1);
    chk("pre_reset_rd_row", 32'(rd_row), 2);
    chk("pre_reset_active_src", 32'(active_src), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_fetch_reset");
    src_sel = 1'b0;
    repeat (3) step();
    chk_all_zero("held_reset");
    @(negedge clk);
    reset   = 1'b1;
    req_cnt = 0;
    check_slot(mk(3'd0, 24'h000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00), 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
